// File: rtl/spi_ram_ctrl.sv
// -----------------------------------------------------------------------------
// spi_ram_ctrl
//
// SPI-slave front end for the single-port RAM block. Frames of DATA_WIDTH+2
// bits arrive MSB first on MOSI while SS_n is low. The two leading bits are
// the RAM command (00 write-addr, 01 write-data, 10 read-addr, 11 read-data),
// followed by DATA_WIDTH bits of address or data. Each completed frame is
// handed to the RAM as rx_data together with a one-cycle rx_valid strobe.
// After a read-data frame, the RAM's answer (tx_data/tx_valid) is shifted out
// on MISO, MSB first.
//
// Handshake: rx_valid is a single-cycle strobe with rx_data valid in that
// cycle and no back-pressure. tx_valid is accepted only while a read-data
// frame is waiting for its answer; it is ignored at every other time.
//
// Optional feature (macro SPI_RAM_CMD_CHECK_EN):
//   adds output cmd_err. A completed frame whose command bits disagree with
//   the decoded state (11 in READ_ADD, 10 in READ_DATA) is dropped and
//   cmd_err pulses instead of rx_valid.
//
// Ports:
//   clk                 system clock, rising edge
//   rst_n               asynchronous active-low reset
//   SS_n                slave select, active-low
//   MOSI                serial data in, MSB first
//   MISO                serial data out, MSB first (0 when idle)
//   rx_data             command word to the RAM din
//   rx_valid            one-cycle strobe, rx_data complete
//   tx_data             RAM read data (dout)
//   tx_valid            RAM read data valid
//   cmd_err             (SPI_RAM_CMD_CHECK_EN only) rejected-frame strobe
//   dbg_state_o         current FSM state
//   dbg_rd_addr_seen_o  read address loaded, next read frame is read-data
// -----------------------------------------------------------------------------
module spi_ram_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  SS_n,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic [DATA_WIDTH+1:0] rx_data,
    output logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
`ifdef SPI_RAM_CMD_CHECK_EN
    output logic                  cmd_err,
`endif
    output logic [2:0]            dbg_state_o,
    output logic                  dbg_rd_addr_seen_o
);

    localparam int FW  = DATA_WIDTH + 2;           // frame width
    localparam int CW  = $clog2(FW);               // frame bit counter width
    localparam int TCW = $clog2(DATA_WIDTH + 1);   // MISO bit counter width
    localparam logic [CW-1:0]  LAST_CNT = CW'(FW - 1);
    localparam logic [TCW-1:0] TX_REST  = TCW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t                state_q;
    logic [CW-1:0]         cnt_q;        // bits captured after the first one
    logic [FW-1:0]         shift_q;      // incoming frame
    logic                  done_q;       // frame already completed/forwarded
    logic                  rd_seen_q;
    logic                  wait_tx_q;    // waiting for the RAM read answer
    logic [DATA_WIDTH-1:0] tx_shift_q;   // remaining bits to send, MSB first
    logic [TCW-1:0]        tx_cnt_q;     // bits still to send after current
    logic                  miso_q;
    logic [FW-1:0]         rx_data_q;
    logic                  rx_valid_q;
`ifdef SPI_RAM_CMD_CHECK_EN
    logic                  cmd_err_q;
`endif

    // Command consistency of the completed frame against the decoded state.
    logic cmd_ok;
    always_comb begin
        cmd_ok = 1'b1;
`ifdef SPI_RAM_CMD_CHECK_EN
        if (state_q == READ_ADD  && shift_q[FW-1:FW-2] == 2'b11) cmd_ok = 1'b0;
        if (state_q == READ_DATA && shift_q[FW-1:FW-2] == 2'b10) cmd_ok = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            done_q     <= 1'b0;
            rd_seen_q  <= 1'b0;
            wait_tx_q  <= 1'b0;
            tx_shift_q <= '0;
            tx_cnt_q   <= '0;
            miso_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
`ifdef SPI_RAM_CMD_CHECK_EN
            cmd_err_q  <= 1'b0;
`endif
        end else begin
            rx_valid_q <= 1'b0;
`ifdef SPI_RAM_CMD_CHECK_EN
            cmd_err_q  <= 1'b0;
`endif
            if (state_q != IDLE && SS_n) begin
                // Deselect aborts everything in flight; rd_seen_q survives.
                state_q    <= IDLE;
                cnt_q      <= '0;
                shift_q    <= '0;
                done_q     <= 1'b0;
                wait_tx_q  <= 1'b0;
                tx_shift_q <= '0;
                tx_cnt_q   <= '0;
                miso_q     <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        miso_q <= 1'b0;
                        if (!SS_n) begin
                            state_q <= CHK_CMD;
                            cnt_q   <= '0;
                            done_q  <= 1'b0;
                        end
                    end
                    CHK_CMD: begin
                        shift_q <= {{(FW-1){1'b0}}, MOSI};
                        cnt_q   <= '0;
                        if (!MOSI)          state_q <= WRITE;
                        else if (rd_seen_q) state_q <= READ_DATA;
                        else                state_q <= READ_ADD;
                    end
                    default: begin  // WRITE, READ_ADD, READ_DATA
                        if (cnt_q != LAST_CNT) begin
                            shift_q <= {shift_q[FW-2:0], MOSI};
                            cnt_q   <= cnt_q + CW'(1);
                        end else if (!done_q) begin
                            // Frame complete; later MOSI bits are ignored.
                            done_q <= 1'b1;
                            if (cmd_ok) begin
                                rx_valid_q <= 1'b1;
                                rx_data_q  <= shift_q;
                                if (state_q == READ_ADD) rd_seen_q <= 1'b1;
                                if (state_q == READ_DATA) begin
                                    rd_seen_q <= 1'b0;
                                    wait_tx_q <= 1'b1;
                                end
                            end
`ifdef SPI_RAM_CMD_CHECK_EN
                            else begin
                                cmd_err_q <= 1'b1;
                            end
`endif
                        end

                        // wait_tx_q is only ever set in READ_DATA, so this
                        // path keeps MISO at 0 in the other data states.
                        if (wait_tx_q && tx_valid) begin
                            wait_tx_q  <= 1'b0;
                            miso_q     <= tx_data[DATA_WIDTH-1];
                            tx_shift_q <= {tx_data[DATA_WIDTH-2:0], 1'b0};
                            tx_cnt_q   <= TX_REST;
                        end else if (tx_cnt_q != '0) begin
                            miso_q     <= tx_shift_q[DATA_WIDTH-1];
                            tx_shift_q <= {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                            tx_cnt_q   <= tx_cnt_q - TCW'(1);
                        end else begin
                            miso_q <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    assign MISO               = miso_q;
    assign rx_data            = rx_data_q;
    assign rx_valid           = rx_valid_q;
`ifdef SPI_RAM_CMD_CHECK_EN
    assign cmd_err            = cmd_err_q;
`endif
    assign dbg_state_o        = state_q;
    assign dbg_rd_addr_seen_o = rd_seen_q;

endmodule
